// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared ADS bus with
// tenure preemption and split-transaction parking.
module bus_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_request,
    input  logic       m2_request,
    input  logic       split_req,
    input  logic       split_ready,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       bus_busy,
    output logic [1:0] owner,
    output logic       split_pending,
    output logic [1:0] split_master,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        M1_OWN = 2'd1,
        M2_OWN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             last_m2, last_m2_nx;
    logic             sp, sp_nx;
    logic [1:0]       sm, sm_nx;

    logic m1_elig, m2_elig;
    logic resume1, resume2;
    logic own_req, other_elig;

    // A parked master stays ineligible until the slave signals ready.
    assign m1_elig = m1_request & ~(sp & (sm == 2'd1) & ~split_ready);
    assign m2_elig = m2_request & ~(sp & (sm == 2'd2) & ~split_ready);

    assign resume1 = sp & split_ready & (sm == 2'd1) & m1_request;
    assign resume2 = sp & split_ready & (sm == 2'd2) & m2_request;

    assign own_req    = (state == M1_OWN) ? m1_request : m2_request;
    assign other_elig = (state == M1_OWN) ? m2_elig : m1_elig;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            last_m2 <= 1'b1;
            sp      <= 1'b0;
            sm      <= 2'd0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            last_m2 <= last_m2_nx;
            sp      <= sp_nx;
            sm      <= sm_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        last_m2_nx = last_m2;
        sp_nx      = sp;
        sm_nx      = sm;
        preempt    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                // Ready clears the record whether the master resumes or
                // has abandoned its request.
                if (sp & split_ready) begin
                    sp_nx = 1'b0;
                    sm_nx = 2'd0;
                end
                if (resume1) begin
                    state_nx = M1_OWN;
                end else if (resume2) begin
                    state_nx = M2_OWN;
                end else if (m1_elig & m2_elig) begin
                    state_nx = last_m2 ? M1_OWN : M2_OWN;
                end else if (m1_elig) begin
                    state_nx = M1_OWN;
                end else if (m2_elig) begin
                    state_nx = M2_OWN;
                end
                if (state_nx == M1_OWN) last_m2_nx = 1'b0;
                if (state_nx == M2_OWN) last_m2_nx = 1'b1;
            end
            M1_OWN, M2_OWN: begin
                if (split_req & ~sp) begin
                    sp_nx    = 1'b1;
                    sm_nx    = state;
                    state_nx = IDLE;
                end else if (!own_req) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_MAX && other_elig) begin
                    state_nx = IDLE;
                    preempt  = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign m1_grant      = (state == M1_OWN);
    assign m2_grant      = (state == M2_OWN);
    assign bus_busy      = m1_grant | m2_grant;
    assign owner         = state;
    assign split_pending = sp;
    assign split_master  = sm;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus a random run
// checked against a tenure-counting reference model.
module tb_bus_arbiter;

    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m1_request = 1'b0;
    logic       m2_request = 1'b0;
    logic       split_req = 1'b0;
    logic       split_ready = 1'b0;
    logic       m1_grant, m2_grant, bus_busy;
    logic [1:0] owner;
    logic       split_pending;
    logic [1:0] split_master;
    logic       preempt;

    int checks = 0;
    int failures = 0;

    // reference model: owner id, cycles granted so far, split record
    int mo, mten, mlast, msm;
    bit msp;
    bit pre_seen, pre_exp;

    bus_arbiter #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .m1_request   (m1_request),
        .m2_request   (m2_request),
        .split_req    (split_req),
        .split_ready  (split_ready),
        .m1_grant     (m1_grant),
        .m2_grant     (m2_grant),
        .bus_busy     (bus_busy),
        .owner        (owner),
        .split_pending(split_pending),
        .split_master (split_master),
        .preempt      (preempt)
    );

    always #5 clk = ~clk;

    logic [7:0] obs;
    assign obs = {m1_grant, m2_grant, bus_busy, owner,
                  split_pending, split_master};

    function automatic logic [7:0] exp_vec(input int o, input bit s,
                                           input int m);
        return {o == 1, o == 2, o != 0, 2'(o), s, 2'(m)};
    endfunction

    task automatic model_reset();
        mo = 0; mten = 0; mlast = 2; msp = 0; msm = 0;
    endtask

    task automatic step(input bit a, input bit b, input bit s,
                        input bit r);
        bit e1, e2, mine, oe;
        @(negedge clk);
        m1_request = a; m2_request = b;
        split_req = s; split_ready = r;
        #1;
        pre_seen = preempt;
        e1 = a && !(msp && msm == 1 && !r);
        e2 = b && !(msp && msm == 2 && !r);
        mine = (mo == 1) ? a : b;
        oe = (mo == 1) ? e2 : e1;
        pre_exp = (mo != 0) && !(s && !msp) && mine &&
                  (mten >= HOLD) && oe;
        @(posedge clk);
        if (mo == 0) begin
            if (msp && r) begin
                if ((msm == 1) ? a : b) mo = msm;
                msp = 0; msm = 0;
            end
            if (mo == 0) begin
                if (e1 && e2) mo = (mlast == 1) ? 2 : 1;
                else if (e1) mo = 1;
                else if (e2) mo = 2;
            end
            if (mo != 0) begin mlast = mo; mten = 1; end
        end else if (s && !msp) begin
            msp = 1; msm = mo; mo = 0;
        end else if (!mine || pre_exp) begin
            mo = 0;
        end else begin
            mten++;
        end
        #1;
    endtask

    task automatic do_reset();
        m1_request = 0; m2_request = 0;
        split_req = 0; split_ready = 0;
        @(posedge clk);
        #3 reset = 1'b1;
        model_reset();
        #1;
        if (obs !== 8'd0 || preempt !== 1'b0) begin
            failures++;
            $display("FAIL async_reset obs=%b pre=%b exp=0", obs, preempt);
        end
        checks++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        model_reset();
        if (obs !== 8'd0 || preempt !== 1'b0) begin
            failures++;
            $display("FAIL reset_state obs=%b exp=0", obs);
        end
        checks++;
        @(negedge clk);
        reset = 1'b0;
        step(1, 1, 0, 0);
        if (obs !== exp_vec(1, 0, 0)) begin
            failures++;
            $display("FAIL tie_m1 obs=%b exp=%b", obs, exp_vec(1, 0, 0));
        end
        checks++;
        repeat (3) step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        if (obs !== exp_vec(0, 0, 0)) begin
            failures++;
            $display("FAIL dead_cycle obs=%b exp=%b", obs, exp_vec(0, 0, 0));
        end
        checks++;
        step(0, 1, 0, 0);
        if (obs !== exp_vec(2, 0, 0)) begin
            failures++;
            $display("FAIL tie_m2 obs=%b exp=%b", obs, exp_vec(2, 0, 0));
        end
        checks++;
    endtask

    task automatic test_round_robin();
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        if (obs !== exp_vec(2, 0, 0)) begin
            failures++;
            $display("FAIL round_robin obs=%b exp=%b", obs, exp_vec(2, 0, 0));
        end
        checks++;
        step(0, 0, 0, 0);
    endtask

    task automatic test_preempt();
        int n1, n2, np;
        bit last_pre;
        do_reset();
        step(1, 1, 0, 0);
        n1 = 1; np = 0; last_pre = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 0, 0);
            if (pre_seen) np++;
            if (!m1_grant) begin last_pre = pre_seen; break; end
            n1++;
        end
        if (n1 != HOLD || np != 1 || !last_pre) begin
            failures++;
            $display("FAIL preempt_m1 len=%0d pulses=%0d last=%0d exp=%0d/1/1",
                     n1, np, last_pre, HOLD);
        end
        checks++;
        step(1, 1, 0, 0);
        n2 = 0;
        for (int i = 0; i < 40; i++) begin
            if (!m2_grant) break;
            n2++;
            step(1, 1, 0, 0);
        end
        if (n2 != HOLD) begin
            failures++;
            $display("FAIL preempt_m2 len=%0d exp=%0d", n2, HOLD);
        end
        checks++;
        step(1, 1, 0, 0);
        if (obs !== exp_vec(1, 0, 0)) begin
            failures++;
            $display("FAIL alternate obs=%b exp=%b", obs, exp_vec(1, 0, 0));
        end
        checks++;
    endtask

    task automatic test_saturate();
        int np;
        do_reset();
        np = 0;
        repeat (20) begin
            step(1, 0, 0, 0);
            if (pre_seen) np++;
        end
        if (m1_grant !== 1'b1 || np != 0) begin
            failures++;
            $display("FAIL saturate grant=%b pulses=%0d exp=1/0", m1_grant, np);
        end
        checks++;
        step(1, 1, 0, 0);
        if (pre_seen !== 1'b1 || obs !== exp_vec(0, 0, 0)) begin
            failures++;
            $display("FAIL late_preempt pre=%b obs=%b exp=1/%b",
                     pre_seen, obs, exp_vec(0, 0, 0));
        end
        checks++;
    endtask

    task automatic test_split();
        do_reset();
        step(0, 0, 1, 0);
        if (obs !== exp_vec(0, 0, 0)) begin
            failures++;
            $display("FAIL split_idle obs=%b exp=%b", obs, exp_vec(0, 0, 0));
        end
        checks++;
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        if (obs !== exp_vec(0, 1, 1) || pre_seen !== 1'b0) begin
            failures++;
            $display("FAIL split_park obs=%b exp=%b", obs, exp_vec(0, 1, 1));
        end
        checks++;
        step(1, 1, 0, 0);
        if (obs !== exp_vec(2, 1, 1)) begin
            failures++;
            $display("FAIL split_other obs=%b exp=%b", obs, exp_vec(2, 1, 1));
        end
        checks++;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        step(1, 0, 0, 1);
        if (obs !== exp_vec(0, 1, 1)) begin
            failures++;
            $display("FAIL split_wait obs=%b exp=%b", obs, exp_vec(0, 1, 1));
        end
        checks++;
        step(1, 0, 0, 1);
        if (obs !== exp_vec(1, 0, 0)) begin
            failures++;
            $display("FAIL split_resume obs=%b exp=%b", obs, exp_vec(1, 0, 0));
        end
        checks++;
    endtask

    task automatic test_split_collision();
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        if (obs !== exp_vec(0, 1, 1)) begin
            failures++;
            $display("FAIL split_drop obs=%b exp=%b", obs, exp_vec(0, 1, 1));
        end
        checks++;
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        if (obs !== exp_vec(2, 1, 1)) begin
            failures++;
            $display("FAIL split_twice obs=%b exp=%b", obs, exp_vec(2, 1, 1));
        end
        checks++;
        step(0, 0, 0, 0);
        step(0, 1, 0, 1);
        if (obs !== exp_vec(2, 0, 0)) begin
            failures++;
            $display("FAIL split_abandon obs=%b exp=%b", obs, exp_vec(2, 0, 0));
        end
        checks++;
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        do_reset();
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        step(0, 1, 0, 0);
        do_reset();
        step(1, 1, 0, 0);
        if (obs !== exp_vec(1, 0, 0)) begin
            failures++;
            $display("FAIL reset_tie obs=%b exp=%b", obs, exp_vec(1, 0, 0));
        end
        checks++;
    endtask

    task automatic test_random();
        bit a, b, r;
        a = 0; b = 0; r = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) a = !a;
            if ($urandom_range(0, 7) == 0) b = !b;
            if ($urandom_range(0, 5) == 0) r = !r;
            step(a, b, $urandom_range(0, 9) == 0, r);
            if ({obs, pre_seen} !== {exp_vec(mo, msp, msm), pre_exp}) begin
                failures++;
                $display("FAIL random cyc=%0d obs=%b pre=%b exp=%b pre=%b",
                         i, obs, pre_seen, exp_vec(mo, msp, msm), pre_exp);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_preempt();
        test_saturate();
        test_split();
        test_split_collision();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
